// File: rtl/axi_wmst_burst_if.sv
// ----------------------------------------------------------------------------
// axi_wmst_burst_if
// AXI4 write-channel bundle (AW/W/B) between the write-master burst engine and
// the interconnect.
//
// Parameters
//   DATA_W  data width in bits (strobe width is DATA_W/8)
//   ADDR_W  address width in bits
//
// Modports
//   master  burst engine side: drives AW/W payload and valids, bready
//   slave   interconnect side: drives awready, wready, bvalid, bresp
// ----------------------------------------------------------------------------
interface axi_wmst_burst_if #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 64
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp,
      output bready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp,
      input  bready
   );
endinterface

// File: rtl/axi_wmst_burst.sv
// ----------------------------------------------------------------------------
// axi_wmst_burst
// Write-master burst engine. Takes one write command (byte address + byte
// count), streams the flattener's words onto an AXI4 write channel as an INCR
// burst and pulses wmst_done after the write response. One command in flight.
//
// Optional build macro: WMST_4K_SPLIT_EN
//   defined   - a command whose bytes would cross a 4 KB boundary is issued as
//               several bursts, each cut at the next 4 KB boundary
//               (AW->W->B repeated), with one wmst_done after the final B.
//   undefined - always a single burst; caller guarantees no 4 KB crossing.
//
// Parameters
//   DATA_W     stream / AXI data width (beat = 64 bytes at 512)
//   ADDR_W     address and transfer-size width
//   MAX_BEATS  beats per command ceiling (1..256)
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   wmst_req         command strobe, only sampled when idle
//   wmst_addr        byte address, low 6 bits ignored
//   wmst_xfer_size   byte count, multiple of 64, zero allowed
//   wmst_done        one-cycle completion pulse
//   wmst_busy        accepted command until done pulse (inclusive)
//   wmst_err         sticky error: bad BRESP or size clamped; cleared by req
//   s_tdata/s_tvalid/s_tready  input stream, passed straight onto W
//   axi              AXI4 AW/W/B master port
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for wmst_req
// AW     | awvalid high, address/len held until awready
// W      | stream passed through to W until the last beat handshakes
// BRESP  | bready high, waiting for bvalid
// DONE   | wmst_done pulse, back to IDLE next cycle
// ----------------------------------------------------------------------------
module axi_wmst_burst #(
   parameter int DATA_W    = 512,
   parameter int ADDR_W    = 64,
   parameter int MAX_BEATS = 256
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                wmst_req,
   input  logic [ADDR_W-1:0]   wmst_addr,
   input  logic [ADDR_W-1:0]   wmst_xfer_size,
   output logic                wmst_done,
   output logic                wmst_busy,
   output logic                wmst_err,

   input  logic [DATA_W-1:0]   s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,

   axi_wmst_burst_if.master    axi
);

   // wide enough for 0..256 beats
   localparam int BEAT_W = 9;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AW    = 3'd1,
      S_W     = 3'd2,
      S_BRESP = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state;
   logic [ADDR_W-1:0]    awaddr_q;
   logic [7:0]           awlen_q;
   logic [7:0]           beat_cnt;
   logic                 awvalid_q;
   logic                 bready_q;
   logic                 done_q;
   logic                 busy_q;
   logic                 err_q;

   // --- command decode ------------------------------------------------------
   logic [ADDR_W-1:0]    req_addr;
   logic [ADDR_W-1:0]    size_beats;
   logic                 clamp;
   logic [BEAT_W-1:0]    req_beats;
   logic [BEAT_W-1:0]    first_beats;
   logic                 unused_bits;

   assign req_addr    = {wmst_addr[ADDR_W-1:6], 6'b0};
   assign size_beats  = wmst_xfer_size >> 6;
   assign clamp       = size_beats > ADDR_W'(MAX_BEATS);
   assign req_beats   = clamp ? BEAT_W'(MAX_BEATS) : size_beats[BEAT_W-1:0];
   assign unused_bits = ^{wmst_addr[5:0], wmst_xfer_size[5:0]};

`ifdef WMST_4K_SPLIT_EN
   // Beats left before the next 4 KB boundary (1..64). Every follow-on burst
   // starts exactly on a boundary, so it can carry at most 64 beats.
   logic [BEAT_W-1:0]    room_req;
   logic [BEAT_W-1:0]    rem_beats;
   logic [BEAT_W-1:0]    nxt_beats;
   logic [ADDR_W-1:0]    next_addr;
   logic [ADDR_W-1:0]    req_boundary;

   assign room_req     = BEAT_W'(7'd64 - {1'b0, req_addr[11:6]});
   assign first_beats  = (req_beats > room_req) ? room_req : req_beats;
   assign nxt_beats    = (rem_beats > BEAT_W'(64)) ? BEAT_W'(64) : rem_beats;
   assign req_boundary = {req_addr[ADDR_W-1:12] + (ADDR_W-12)'(1), 12'h000};
`else
   assign first_beats  = req_beats;
`endif

   // --- sequencer -----------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         beat_cnt  <= '0;
         awvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef WMST_4K_SPLIT_EN
         rem_beats <= '0;
         next_addr <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wmst_req) begin
                  busy_q <= 1'b1;
                  err_q  <= clamp;
                  if (req_beats == '0) begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     awaddr_q  <= req_addr;
                     awlen_q   <= 8'(first_beats - BEAT_W'(1));
                     awvalid_q <= 1'b1;
                     state     <= S_AW;
`ifdef WMST_4K_SPLIT_EN
                     rem_beats <= req_beats - first_beats;
                     next_addr <= req_boundary;
`endif
                  end
               end
            end

            S_AW: begin
               if (axi.awready) begin
                  awvalid_q <= 1'b0;
                  beat_cnt  <= '0;
                  state     <= S_W;
               end
            end

            S_W: begin
               if (axi.wvalid && axi.wready) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_cnt == awlen_q) begin
                     bready_q <= 1'b1;
                     state    <= S_BRESP;
                  end
               end
            end

            S_BRESP: begin
               if (axi.bvalid) begin
                  bready_q <= 1'b0;
                  if (axi.bresp != 2'b00)
                     err_q <= 1'b1;
`ifdef WMST_4K_SPLIT_EN
                  if (rem_beats != '0) begin
                     awaddr_q  <= next_addr;
                     awlen_q   <= 8'(nxt_beats - BEAT_W'(1));
                     rem_beats <= rem_beats - nxt_beats;
                     next_addr <= next_addr + ADDR_W'(4096);
                     awvalid_q <= 1'b1;
                     state     <= S_AW;
                  end else
`endif
                  begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // --- outputs -------------------------------------------------------------
   // W is a pure pass-through of the stream while in W: no skid buffer, so
   // the flattener sees wready directly and gaps in s_tvalid become W gaps.
   logic in_w;
   assign in_w = (state == S_W);

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.awlen   = awlen_q;
   assign axi.awsize  = 3'd6;
   assign axi.awburst = 2'b01;

   assign axi.wvalid  = in_w & s_tvalid;
   assign axi.wdata   = in_w ? s_tdata : '0;
   assign axi.wstrb   = '1;
   assign axi.wlast   = in_w & (beat_cnt == awlen_q);
   assign s_tready    = in_w & axi.wready;

   assign axi.bready  = bready_q;

   assign wmst_done   = done_q;
   assign wmst_busy   = busy_q;
   assign wmst_err    = err_q;

endmodule

// File: tb/tb_axi_wmst_burst.sv
// ----------------------------------------------------------------------------
// tb_axi_wmst_burst
// Randomized scoreboard bench for axi_wmst_burst. Each command is expanded by a
// byte/beat-level reference model into expected AW bursts, W beats and a done
// record; independent processes drive the stream and a randomly stalling AXI
// slave, and a monitor pops expectations as the DUT presents transfers.
// ----------------------------------------------------------------------------
module tb_axi_wmst_burst;
   localparam int DATA_W    = 512;
   localparam int ADDR_W    = 64;
   localparam int MAX_BEATS = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                wmst_req = 1'b0;
   logic [ADDR_W-1:0]   wmst_addr = '0;
   logic [ADDR_W-1:0]   wmst_xfer_size = '0;
   logic                wmst_done, wmst_busy, wmst_err;
   logic [DATA_W-1:0]   s_tdata = '0;
   logic                s_tvalid = 1'b0;
   logic                s_tready;

   axi_wmst_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

   axi_wmst_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wmst_req       (wmst_req),
      .wmst_addr      (wmst_addr),
      .wmst_xfer_size (wmst_xfer_size),
      .wmst_done      (wmst_done),
      .wmst_busy      (wmst_busy),
      .wmst_err       (wmst_err),
      .s_tdata        (s_tdata),
      .s_tvalid       (s_tvalid),
      .s_tready       (s_tready),
      .axi            (axi)
   );

   typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } aw_t;
   typedef struct { logic [DATA_W-1:0] data; logic last; } w_t;
   typedef struct { logic err; logic zero; int cyc; } done_t;

   aw_t               exp_aw[$];
   w_t                exp_w[$];
   done_t             exp_done[$];
   logic [DATA_W-1:0] stream_q[$];
   logic [1:0]        resp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit finished = 0;
   bit mon_off = 0;

   int aw_pct = 100, w_pct = 100, s_pct = 100, b_pct = 100;

   bit s_hs = 0, b_hs = 0, wl_hs = 0;
   int b_pending = 0;
   bit w_active = 0, b_active = 0;
   bit prev_aw_stall = 0, prev_done = 0;
   logic [ADDR_W-1:0] prev_awaddr;
   logic [7:0]        prev_awlen;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // --- stream source (flattener) -------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (s_hs && stream_q.size() > 0) void'(stream_q.pop_front());
         if (stream_q.size() > 0 && $urandom_range(1, 100) <= s_pct) begin
            s_tvalid = 1'b1;
            s_tdata  = stream_q[0];
         end else begin
            s_tvalid = 1'b0;
         end
         #1;
         s_hs = s_tvalid & s_tready;
      end
   end

   // --- AXI slave -----------------------------------------------------------
   initial begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (b_hs) begin
            axi.bvalid = 1'b0;
            axi.bresp  = 2'b00;
         end
         if (wl_hs) b_pending++;
         if (!axi.bvalid && b_pending > 0 && $urandom_range(1, 100) <= b_pct) begin
            axi.bvalid = 1'b1;
            if (resp_q.size() > 0) axi.bresp = resp_q.pop_front();
            else axi.bresp = 2'b00;
            b_pending--;
         end
         axi.awready = ($urandom_range(1, 100) <= aw_pct);
         axi.wready  = ($urandom_range(1, 100) <= w_pct);
         #1;
         b_hs  = axi.bvalid & axi.bready;
         wl_hs = axi.wvalid & axi.wready & axi.wlast;
      end
   end

   // --- monitor / scoreboard ------------------------------------------------
   aw_t   m_aw;
   w_t    m_w;
   done_t m_d;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && !mon_off) begin
            if (prev_aw_stall) begin
               check("aw_hold_valid", axi.awvalid, 1'b1);
               check("aw_hold_addr", axi.awaddr, prev_awaddr);
               check("aw_hold_len", axi.awlen, prev_awlen);
            end
            check("wvalid", axi.wvalid, w_active & s_tvalid);
            check("s_tready", s_tready, w_active & axi.wready);
            check("bready", axi.bready, b_active);
            if (prev_done) begin
               check("done_width", wmst_done, 1'b0);
               check("busy_after_done", wmst_busy, 1'b0);
            end
            if (axi.awvalid && axi.awready) begin
               check("awsize", axi.awsize, 3'd6);
               check("awburst", axi.awburst, 2'b01);
               if (exp_aw.size() == 0) begin
                  check("aw_unexpected", 1'b1, 1'b0);
               end else begin
                  m_aw = exp_aw.pop_front();
                  check("awaddr", axi.awaddr, m_aw.addr);
                  check("awlen", axi.awlen, m_aw.len);
               end
            end
            if (axi.wvalid) check("wdata_pass", axi.wdata, s_tdata);
            if (axi.wvalid && axi.wready) begin
               check("wstrb", axi.wstrb, {(DATA_W/8){1'b1}});
               if (exp_w.size() == 0) begin
                  check("w_unexpected", 1'b1, 1'b0);
               end else begin
                  m_w = exp_w.pop_front();
                  check("wdata", axi.wdata, m_w.data);
                  check("wlast", axi.wlast, m_w.last);
                  if (m_w.last) begin
                     w_active = 0;
                     b_active = 1;
                  end
               end
            end
            if (axi.bvalid && axi.bready) b_active = 0;
            if (axi.awvalid && axi.awready) w_active = 1;
            if (wmst_done) begin
               check("busy_at_done", wmst_busy, 1'b1);
               if (exp_done.size() == 0) begin
                  check("done_unexpected", 1'b1, 1'b0);
               end else begin
                  m_d = exp_done.pop_front();
                  check("done_err", wmst_err, m_d.err);
                  if (m_d.zero) check("zero_latency", cyc, m_d.cyc + 1);
               end
            end
            prev_aw_stall = axi.awvalid & ~axi.awready;
            prev_awaddr   = axi.awaddr;
            prev_awlen    = axi.awlen;
            prev_done     = wmst_done;
         end
      end
   end

   // --- reference model + command driver ------------------------------------
   // bad_mode: 0 all OKAY, 1 all SLVERR, 2 occasional random error response
   task automatic issue(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] size,
                        input int bad_mode, input bit junk);
      int guard = 0;
      longint unsigned beats, rem, n;
      logic [ADDR_W-1:0] a;
      bit clamp, err, zero;
      logic [1:0] r;
      logic [DATA_W-1:0] d;
      done_t dn;
      @(negedge clk);
      while (wmst_busy && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20000) check("idle_timeout", wmst_busy, 1'b0);

      beats = size / 64;
      clamp = beats > MAX_BEATS;
      if (clamp) beats = MAX_BEATS;
      zero = (beats == 0);
      err  = clamp;
      a    = addr & ~ADDR_W'(63);
      rem  = beats;
      while (rem > 0) begin
`ifdef WMST_4K_SPLIT_EN
         n = (4096 - longint'(a % 4096)) / 64;
         if (n > rem) n = rem;
`else
         n = rem;
`endif
         exp_aw.push_back('{addr: a, len: 8'(n - 1)});
         r = 2'b00;
         if (bad_mode == 1) r = 2'b10;
         else if (bad_mode == 2 && $urandom_range(0, 7) == 0) r = $urandom_range(0, 1) ? 2'b10 : 2'b11;
         resp_q.push_back(r);
         if (r != 2'b00) err = 1;
         for (longint unsigned k = 0; k < n; k++) begin
            d = rand_word();
            stream_q.push_back(d);
            exp_w.push_back('{data: d, last: (k == n - 1)});
         end
         a   = a + ADDR_W'(n * 64);
         rem = rem - n;
      end
      dn.err  = err;
      dn.zero = zero;
      dn.cyc  = cyc;
      exp_done.push_back(dn);

      wmst_req       = 1'b1;
      wmst_addr      = addr;
      wmst_xfer_size = size;
      @(negedge clk);
      wmst_req       = 1'b0;
      wmst_addr      = {$urandom, $urandom};
      wmst_xfer_size = ADDR_W'($urandom_range(1, 8) * 64);
      #2;
      check("busy_after_req", wmst_busy, 1'b1);
      check("err_after_req", wmst_err, clamp);
      check("awvalid_after_req", axi.awvalid, !zero);
      check("done_after_req", wmst_done, zero);

      if (junk) begin
         for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (wmst_busy && $urandom_range(0, 2) == 0) begin
               wmst_req = 1'b1;
               @(negedge clk);
               wmst_req = 1'b0;
            end
         end
      end
   endtask

   task automatic drain();
      int guard = 0;
      while ((wmst_busy || exp_done.size() > 0) && guard < 30000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 30000) check("drain_timeout", 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("aw_left", exp_aw.size(), 0);
      check("w_left", exp_w.size(), 0);
      check("done_left", exp_done.size(), 0);
   endtask

   task automatic set_knobs(input int a, input int w, input int s, input int b);
      aw_pct = a; w_pct = w; s_pct = s; b_pct = b;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2;
      check("rst_awvalid", axi.awvalid, 1'b0);
      check("rst_awaddr", axi.awaddr, '0);
      check("rst_awlen", axi.awlen, '0);
      check("rst_awsize", axi.awsize, 3'd6);
      check("rst_awburst", axi.awburst, 2'b01);
      check("rst_wvalid", axi.wvalid, 1'b0);
      check("rst_wstrb", axi.wstrb, {(DATA_W/8){1'b1}});
      check("rst_wlast", axi.wlast, 1'b0);
      check("rst_wdata", axi.wdata, '0);
      check("rst_bready", axi.bready, 1'b0);
      check("rst_done", wmst_done, 1'b0);
      check("rst_busy", wmst_busy, 1'b0);
      check("rst_err", wmst_err, 1'b0);
      check("rst_s_tready", s_tready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      set_knobs(100, 100, 100, 100);
      issue(64'h1000, 64'd128, 0, 0);
      issue(64'h2000, 64'd0, 0, 0);
      set_knobs(20, 70, 40, 50);
      issue(64'h3000, 64'd128, 0, 0);
      set_knobs(100, 100, 100, 100);
      issue(64'h4000, 64'd192, 1, 0);
      issue(64'h5000, 64'd64, 0, 0);
      set_knobs(80, 80, 80, 60);
      issue(64'h6000, 64'd19200, 0, 1);
      issue(64'h0FC0, 64'd128, 0, 0);
      issue(64'h7025, 64'd64, 0, 0);
      issue(64'h8FFF, 64'd256, 2, 1);
      drain();

      for (int i = 0; i < 40; i++) begin
         int r;
         longint unsigned nb;
         set_knobs($urandom_range(50, 100), $urandom_range(50, 100),
                   $urandom_range(50, 100), $urandom_range(30, 100));
         r = $urandom_range(0, 9);
         if (r == 0) nb = 0;
         else if (r == 1) nb = $urandom_range(250, 320);
         else nb = $urandom_range(1, 20);
         issue({$urandom, $urandom}, ADDR_W'(nb * 64), 2, $urandom_range(0, 1));
      end
      drain();

      // asynchronous reset in the middle of a burst
      set_knobs(100, 100, 100, 100);
      issue(64'hA000, 64'd1024, 0, 0);
      repeat (5) @(negedge clk);
      #3;
      mon_off = 1;
      rst_n = 1'b0;
      #1;
      check("arst_awvalid", axi.awvalid, 1'b0);
      check("arst_wvalid", axi.wvalid, 1'b0);
      check("arst_s_tready", s_tready, 1'b0);
      check("arst_bready", axi.bready, 1'b0);
      check("arst_busy", wmst_busy, 1'b0);
      exp_aw.delete(); exp_w.delete(); exp_done.delete();
      stream_q.delete(); resp_q.delete();
      s_hs = 0; b_hs = 0; wl_hs = 0; b_pending = 0;
      axi.bvalid = 1'b0; axi.bresp = 2'b00;
      w_active = 0; b_active = 0; prev_aw_stall = 0; prev_done = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mon_off = 0;
      issue(64'hB000, 64'd128, 0, 0);
      drain();

      finished = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      repeat (95000) @(posedge clk);
      if (!finished) begin
         n_cmp++;
         n_bad++;
         $display("FAIL watchdog: simulation did not complete within cycle budget");
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

endmodule
